cover_reader: RTL and testbench

COVER_READER -- requirements
Module: cover_reader

---
 rtl/cover_pkg.sv | 15 +
 rtl/cover_fifo2.sv | 59 +++++
 rtl/cover_reader.sv | 167 ++++++++++++++++
 tb/tb_cover_reader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cover_pkg.sv
// Shared types and constants for the cover_reader burst reader.
package cover_pkg;

  // Burst reader control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Return-data buffer depth, and the width of an occupancy count 0..depth.
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/cover_fifo2.sv
// Two-entry synchronous FIFO that buffers SRAM read data ahead of the stream port.
// Push is ignored when full and pop is ignored when empty; the head word is
// always visible on pop_data.
module cover_fifo2
  import cover_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy update on each accepted push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage is reset too, so the head word (and therefore the
      // stream data output) reads as zero straight out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so simultaneous push and pop see a consistent state.
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/cover_reader.sv
// Burst reader: fetches `length` consecutive SRAM words starting at base_addr
// and streams them out over a ready/valid port in address order.
// Optional feature macro COVER_READER_LOOP_EN adds a `loop` input that makes
// the burst restart at base_addr instead of finishing.
module cover_reader
  import cover_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
`ifdef COVER_READER_LOOP_EN
  input  logic                  loop,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  // Counters span 0..2^ADDR_WIDTH so a full-address-space burst terminates.
  localparam int CW = ADDR_WIDTH + 1;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         issued_q;
  logic [CW-1:0]         accepted_q;
  logic                  inflight_q;
  logic                  done_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_WIDTH-1:0] fifo_data;

  logic                  pop;
  logic [2:0]            occupancy;
  logic                  room;
  logic                  issue;
  logic                  last_issue;
  logic                  last_accept;
  logic                  loop_now;
  logic                  start_ok;
  logic                  start_zero;

`ifdef COVER_READER_LOOP_EN
  assign loop_now = loop;
`else
  assign loop_now = 1'b0;
`endif

  // Starts are only honoured in IDLE; a zero-length start just echoes done.
  assign start_ok   = start && (state_q == IDLE) && (length != '0);
  assign start_zero = start && (state_q == IDLE) && (length == '0);

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;

  // A read may be issued only if the word it returns is guaranteed a slot:
  // buffered words plus the word landing this cycle, minus this cycle's pop.
  assign occupancy = 3'(fifo_count) + 3'(inflight_q);
  assign room      = ((occupancy - 3'(pop)) < 3'(FIFO_DEPTH)) && !(fifo_full && inflight_q);

  assign issue      = (state_q == READ) && room;
  assign last_issue = issue && ((issued_q + CW'(1)) == len_q);

  // The final word is the last of its pass with nothing else buffered or
  // outstanding, which also covers earlier passes still draining in loop mode.
  assign last_accept = (state_q == DRAIN) && pop
                     && ((accepted_q + CW'(1)) == len_q)
                     && (fifo_count == FIFO_CNT_W'(1)) && !inflight_q;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign sram_en   = issue;
  assign sram_we   = 1'b0;
  assign sram_addr = addr_q;
  assign m_data    = fifo_data;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting every always_comb output first means no path leaves it
    // unassigned, so no latch can be inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)                  state_d = READ;
      READ:    if (last_issue && !loop_now)   state_d = DRAIN;
      DRAIN:   if (last_accept)               state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // Burst bookkeeping: address generation, issue/accept counters, done pulse.
  // inflight_q clearing on reset is what discards any word still returning
  // from the SRAM, including data seen in the first cycle after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= start_zero || last_accept;
      inflight_q <= issue;
      if (start_ok) begin
        base_q     <= base_addr;
        addr_q     <= base_addr;
        len_q      <= length;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (issue) begin
          if (last_issue && loop_now) begin
            addr_q   <= base_q;
            issued_q <= '0;
          end else begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            issued_q <= issued_q + CW'(1);
          end
        end
        if (pop) begin
          accepted_q <= ((accepted_q + CW'(1)) == len_q) ? '0 : accepted_q + CW'(1);
        end
      end
    end
  end

  // Return-data buffer.
  cover_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (sram_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_cover_reader.sv
// Self-checking bench for cover_reader: SRAM model, scoreboard queues of
// expected addresses/words, a table of bursts and hand-written corner cases.
module tb_cover_reader;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          loop;
  logic          busy;
  logic          done;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  always #5 clk = ~clk;

  cover_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
`ifdef COVER_READER_LOOP_EN
    .loop      (loop),
`endif
    .busy      (busy),
    .done      (done),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
  );

  // Preloaded memory contents as a function of address.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h3C;
  endfunction

  // SRAM model: data one cycle after a read request, junk otherwise.
  always @(posedge clk or posedge reset) begin
    if (reset)                    sram_data <= 8'h00;
    else if (sram_en && !sram_we) sram_data <= mem_fn(sram_addr);
    else                          sram_data <= 8'hEE;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and monitor state.
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  bit            mon_en = 1'b0;
  int            cyc = 0;
  int            issued_tot, accepted_tot, done_cnt;
  int            first_issue, last_issue_c, first_acc, last_acc;
  logic [AW-1:0] last_addr;
  bit            final_seen, hold_pend;
  logic [DW-1:0] hold_data;

  // Monitor: compare issues and handshakes against the queues, away from posedge.
  always @(negedge clk) begin
    if (mon_en) begin
      bit            pop;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      cyc++;
      pop = m_valid && m_ready;
      check("sram_we_low", 32'(sram_we), 0);
      if (final_seen) begin
        check("done_after_last", 32'(done), 1);
        check("busy_low_with_done", 32'(busy), 0);
        final_seen = 1'b0;
      end
      if (done) done_cnt++;
      if (hold_pend) begin
        check("hold_valid", 32'(m_valid), 1);
        check("hold_data", 32'(m_data), 32'(hold_data));
      end
      if (sram_en) begin
        check("issue_room", 32'((issued_tot - accepted_tot - int'(pop)) < 2), 1);
        if (exp_addr_q.size() == 0) begin
          check("unexpected_issue", 32'(sram_en), 0);
        end else begin
          ea = exp_addr_q.pop_front();
          check("sram_addr", 32'(sram_addr), 32'(ea));
        end
        last_addr = sram_addr;
        if (first_issue < 0) first_issue = cyc;
        last_issue_c = cyc;
        issued_tot++;
      end
      if (pop) begin
        if (exp_data_q.size() == 0) begin
          check("unexpected_word", 32'(m_valid), 0);
        end else begin
          ed = exp_data_q.pop_front();
          check("m_data", 32'(m_data), 32'(ed));
          if (exp_data_q.size() == 0) final_seen = 1'b1;
        end
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        accepted_tot++;
      end
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            rmode;          // 0 always ready, 1 pattern 1,0,0, 2 random
    bit            stray_start;    // pulse start again mid-burst
    bit            back_to_back;   // expect one issue and one word per cycle
    logic [AW-1:0] exp_last_addr;
  } vec_t;

  function automatic logic ready_at(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic clear_stats();
    issued_tot = 0; accepted_tot = 0; done_cnt = 0;
    first_issue = -1; last_issue_c = -1; first_acc = -1; last_acc = -1;
    final_seen = 1'b0; hold_pend = 1'b0;
  endtask

  task automatic push_exp(input logic [AW-1:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(base + AW'(i));
      exp_data_q.push_back(mem_fn(base + AW'(i)));
    end
  endtask

  task automatic run_burst(input vec_t v);
    int start_cyc;
    bit got;
    clear_stats();
    push_exp(v.base, int'(v.len));
    @(posedge clk); #1;
    start = 1'b1; base_addr = v.base; length = v.len; m_ready = ready_at(v.rmode, 0);
    start_cyc = cyc + 1;
    got = 1'b0;
    for (int k = 1; k < 400 && !got; k++) begin
      @(posedge clk); #1;
      start = v.stray_start && (k == 3);
      if (start) begin base_addr = 16'hAAAA; length = 17'd5; end
      m_ready = ready_at(v.rmode, k);
      if (k == 1) check("busy_after_start", 32'(busy), 1);
      got = (done_cnt > 0);
    end
    start = 1'b0;
    check("burst_done", 32'(got), 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("addr_q_empty", exp_addr_q.size(), 0);
    check("data_q_empty", exp_data_q.size(), 0);
    check("last_addr", 32'(last_addr), 32'(v.exp_last_addr));
    check("busy_idle", 32'(busy), 0);
    check("first_valid_latency", 32'((first_acc - start_cyc) >= 2), 1);
    if (v.back_to_back) begin
      check("issue_span", last_issue_c - first_issue, int'(v.len) - 1);
      check("accept_span", last_acc - first_acc, int'(v.len) - 1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{16'h0010, 17'd4,  0, 1'b0, 1'b1, 16'h0013};
    vecs[1] = '{16'hFFFE, 17'd4,  0, 1'b0, 1'b1, 16'h0001};
    vecs[2] = '{16'h0040, 17'd8,  1, 1'b0, 1'b0, 16'h0047};
    vecs[3] = '{16'h0300, 17'd6,  0, 1'b1, 1'b1, 16'h0305};
    vecs[4] = '{16'h7FFF, 17'd1,  0, 1'b0, 1'b1, 16'h7FFF};
    vecs[5] = '{16'h00FF, 17'd12, 2, 1'b0, 1'b0, 16'h010A};

    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0; loop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sram_en", 32'(sram_en), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_sram_addr", 32'(sram_addr), 0);
    check("rst_m_data", 32'(m_data), 0);
    reset = 1'b0;
    clear_stats();
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    // Zero-length start: done next cycle, no reads, never busy.
    clear_stats();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0500; length = '0;
    @(negedge clk);
    check("zero_done_not_yet", 32'(done), 0);
    check("zero_busy0", 32'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done", 32'(done), 1);
    check("zero_busy1", 32'(busy), 0);
    @(posedge clk); #1;
    check("zero_done_single", 32'(done), 0);
    check("zero_busy2", 32'(busy), 0);
    check("zero_no_issue", issued_tot, 0);

    // Reset at word 3 of a 10-word burst, then a clean 2-word burst.
    clear_stats();
    push_exp(16'h0200, 10);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0200; length = 17'd10; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && accepted_tot < 3; k++) begin
      @(posedge clk); #1;
    end
    check("reached_word3", 32'(accepted_tot >= 3), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_sram_en", 32'(sram_en), 0);
    check("mid_rst_sram_we", 32'(sram_we), 0);
    check("mid_rst_m_valid", 32'(m_valid), 0);
    check("mid_rst_sram_addr", 32'(sram_addr), 0);
    check("mid_rst_m_data", 32'(m_data), 0);
    mon_en = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_stats();
    mon_en = 1'b1;
    run_burst('{16'h0100, 17'd2, 0, 1'b0, 1'b1, 16'h0101});

`ifdef COVER_READER_LOOP_EN
    // Loop mode: two restarts then a final pass, one done at the very end.
    begin
      bit got;
      clear_stats();
      for (int p = 0; p < 3; p++) push_exp(16'h0000, 3);
      @(posedge clk); #1;
      start = 1'b1; base_addr = 16'h0000; length = 17'd3; loop = 1'b1; m_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (issued_tot >= 6) loop = 1'b0;
        got = (done_cnt > 0);
      end
      check("loop_done", 32'(got), 1);
      repeat (3) @(posedge clk);
      #1;
      check("loop_done_pulses", done_cnt, 1);
      check("loop_issues", issued_tot, 9);
      check("loop_addr_q_empty", exp_addr_q.size(), 0);
      check("loop_data_q_empty", exp_data_q.size(), 0);
    end
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
